// File: rtl/inst_sequencer.sv
// inst_sequencer
//   Sits downstream of the instruction buffer. Each instruction is requested
//   with a one-cycle fetch pulse and captured on the buffer's init pulse. The
//   sequencer decodes the 128-bit word and issues load/compute/store commands
//   over a valid/ready/done handshake. It stops on HALT, on the buffer's
//   completion flag, or on an illegal opcode.
//
// Ports
//   clk, reset_n         clock, synchronous active-low reset
//   start, abort         begin execution (idle/done/error only); force idle
//   instruction          instruction word from the buffer
//   init_inst_pulse      instruction is valid this cycle
//   complete_flag        accompanying instruction is the last one
//   fetch_req            one-cycle fetch pulse to the buffer
//   cmd_valid/ready/done command handshake with the execution units
//   cmd_op, cmd_addr_a, cmd_addr_b, cmd_len   command fields
//   busy, done, err      status
//   inst_count           instructions captured since start (saturating)
//
// Instruction layout: [127:124] opcode, [95:64] addr_a, [63:32] addr_b,
// [31:16] len, [15:0] imm; [123:96] ignored.
module inst_sequencer #(
  parameter int INST_BITS = 128,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [INST_BITS-1:0] instruction,
  input  logic                 init_inst_pulse,
  input  logic                 complete_flag,
  output logic                 fetch_req,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  input  logic                 cmd_done,
  output logic [3:0]           cmd_op,
  output logic [ADDR_W-1:0]    cmd_addr_a,
  output logic [ADDR_W-1:0]    cmd_addr_b,
  output logic [LEN_W-1:0]     cmd_len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     inst_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_DECODE,
    S_ISSUE,
    S_EXEC,
    S_DELAY,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_LOAD_W  = 4'd1;
  localparam logic [3:0] OP_LOAD_IN = 4'd2;
  localparam logic [3:0] OP_COMPUTE = 4'd3;
  localparam logic [3:0] OP_STORE   = 4'd4;
  localparam logic [3:0] OP_WAIT    = 4'd5;
  localparam logic [3:0] OP_HALT    = 4'd15;

  state_t state;
  state_t state_n;

  // Captured instruction fields
  logic [3:0]  op_q;
  logic [31:0] addr_a_q;
  logic [31:0] addr_b_q;
  logic [15:0] len_q;
  logic [15:0] imm_q;
  logic        last_q;
  logic [15:0] dcnt;

  // Reserved instruction bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^instruction[123:96];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  function automatic logic is_idle_like(input state_t s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERROR);
  endfunction

  // Where the program continues once the current instruction retires.
  function automatic state_t next_inst(input logic last);
    return last ? S_DONE : S_FETCH;
  endfunction

  function automatic state_t decode_next(input logic [3:0]  op,
                                         input logic [15:0] len,
                                         input logic [15:0] imm,
                                         input logic        last);
    case (op)
      OP_NOP:  return next_inst(last);
      OP_HALT: return S_DONE;
      OP_WAIT: return (imm == 16'd0) ? next_inst(last) : S_DELAY;
      OP_LOAD_W, OP_LOAD_IN, OP_COMPUTE, OP_STORE:
        // Zero-length commands are retired without being issued.
        return (len == 16'd0) ? next_inst(last) : S_ISSUE;
      default: return S_ERROR;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: if (start) state_n = S_FETCH;
        S_FETCH:                 state_n = S_CAPTURE;
        S_CAPTURE:               if (init_inst_pulse) state_n = S_DECODE;
        S_DECODE:                state_n = decode_next(op_q, len_q, imm_q, last_q);
        // cmd_valid is high throughout ISSUE, so ready alone completes it.
        S_ISSUE:                 if (cmd_ready) state_n = S_EXEC;
        S_EXEC:                  if (cmd_done) state_n = next_inst(last_q);
        S_DELAY:                 if (dcnt == 16'd1) state_n = next_inst(last_q);
        default:                 state_n = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      fetch_req  <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_op     <= '0;
      cmd_addr_a <= '0;
      cmd_addr_b <= '0;
      cmd_len    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      inst_count <= '0;
    end else begin
      state     <= state_n;
      fetch_req <= (state_n == S_FETCH);
      cmd_valid <= (state_n == S_ISSUE);
      busy      <= !is_idle_like(state_n);
      done      <= (state_n == S_DONE);
      err       <= (state_n == S_ERROR);

      if (!abort && is_idle_like(state) && start) begin
        inst_count <= '0;
      end

      if (!abort && (state == S_CAPTURE) && init_inst_pulse) begin
        op_q       <= instruction[127:124];
        addr_a_q   <= instruction[95:64];
        addr_b_q   <= instruction[63:32];
        len_q      <= instruction[31:16];
        imm_q      <= instruction[15:0];
        last_q     <= complete_flag;
        inst_count <= sat_inc(inst_count);
      end

      if ((state == S_DECODE) && (state_n == S_DELAY)) begin
        dcnt <= imm_q;
      end else if (state == S_DELAY) begin
        dcnt <= dcnt - 16'd1;
      end

      // Fields are loaded once on entry to ISSUE and held through the handshake.
      if ((state == S_DECODE) && (state_n == S_ISSUE)) begin
        cmd_op     <= op_q;
        cmd_addr_a <= ADDR_W'(addr_a_q);
        cmd_addr_b <= ADDR_W'(addr_b_q);
        cmd_len    <= LEN_W'(len_q);
      end
    end
  end

endmodule
